// File: rtl/cat_recognizer_pkg.sv
// Shared types, error-cause bit positions and the dot-product helper for the
// cat-recognizer accumulator scoreboard.
//   sb_state_t : scoreboard FSM states
//   *_MISMATCH / EARLY_DONE / OVERRUN / TIMEOUT : bit positions in the error vector
//   dot_sum()  : signed sum over channels of unsigned pixel * signed weight
package cat_recognizer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_DONE, REPORT} sb_state_t;

  localparam int unsigned EARLY_DONE      = 0;
  localparam int unsigned OVERRUN         = 1;
  localparam int unsigned TIMEOUT         = 2;
  localparam int unsigned ACC_MISMATCH    = 3;
  localparam int unsigned CAT_MISMATCH    = 4;
  localparam int unsigned STREAM_MISMATCH = 5;
  localparam int unsigned NUM_CAUSES      = 6;

  // Upper bounds of the generic helper; callers zero-extend their buses.
  localparam int unsigned MAX_CHANNELS = 8;
  localparam int unsigned MAX_PIX_W    = 16;
  localparam int unsigned MAX_WGT_W    = 16;
  localparam int unsigned MAX_ACC_W    = 128;
  localparam int unsigned PIX_BUS_W    = MAX_CHANNELS * MAX_PIX_W;
  localparam int unsigned WGT_BUS_W    = MAX_CHANNELS * MAX_WGT_W;

  // Pixel is treated as a non-negative signed value one bit wider than the
  // pixel; the weight is sign-extended from weight_precision bits by a
  // left-shift / arithmetic-right-shift pair.
  function automatic logic signed [MAX_ACC_W-1:0] dot_sum(
    input logic [PIX_BUS_W-1:0] pixels,
    input logic [WGT_BUS_W-1:0] weights,
    input int unsigned          channels,
    input int unsigned          pixel_width,
    input int unsigned          weight_precision
  );
    logic signed [MAX_ACC_W-1:0] sum;
    logic [MAX_PIX_W-1:0]        pmask;
    logic [MAX_PIX_W:0]          px;
    logic signed [MAX_WGT_W-1:0] wt;
    sum   = '0;
    pmask = ~({MAX_PIX_W{1'b1}} << pixel_width);
    for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
      if (k < channels) begin
        px  = {1'b0, MAX_PIX_W'(pixels >> (k * pixel_width)) & pmask};
        wt  = MAX_WGT_W'(weights >> (k * weight_precision)) << (MAX_WGT_W - weight_precision);
        wt  = wt >>> (MAX_WGT_W - weight_precision);
        sum = sum + $signed(px) * wt;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/acc_scoreboard_dot_product_unit.sv
// dot_product_unit: combinational per-sample sum of products.
//   pixels  : Channels unsigned pixels, channel k at [k*Pixel_width +: Pixel_width]
//   weights : Channels signed weights, channel k at [k*Weight_precision +: Weight_precision]
//   dot     : channel sum sign-extended (or wrapped) to Acc_width
module dot_product_unit
  import cat_recognizer_pkg::*;
#(
  parameter int unsigned Channels         = 3,
  parameter int unsigned Pixel_width      = 8,
  parameter int unsigned Weight_precision = 5,
  parameter int unsigned Acc_width        = 64
) (
  input  logic [Channels*Pixel_width-1:0]      pixels,
  input  logic [Channels*Weight_precision-1:0] weights,
  output logic [Acc_width-1:0]                 dot
);

  always_comb begin
    dot = Acc_width'(dot_sum(PIX_BUS_W'(pixels), WGT_BUS_W'(weights),
                             Channels, Pixel_width, Weight_precision));
  end

endmodule

// File: rtl/acc_scoreboard.sv
// acc_scoreboard: incremental reference model and scoreboard for the
// cat-recognizer dot-product engine.
//   clk, rst (sync, active-high), start (arms an image)
//   smp_valid/smp_pixels/smp_weights : sample stream fed to the DUT accumulator
//   dut_acc/dut_acc_valid/dut_cat/dut_done : DUT observation
//   exp_acc, smp_count, busy : model state
//   mismatch (error pulse), err_count (saturating), result_valid/result_pass
module acc_scoreboard
  import cat_recognizer_pkg::*;
#(
  parameter int unsigned Channels         = 3,
  parameter int unsigned Pixel_width      = 8,
  parameter int unsigned Amba_Word        = 24,
  parameter int unsigned Weight_precision = 5,
  parameter int unsigned Pixel_count      = 4096,
  parameter int unsigned Acc_width        = 64,
  parameter int          Threshold        = 0,
  parameter int unsigned Stream_check     = 1,
  parameter int unsigned Timeout          = 1024,
  parameter int unsigned Err_cnt_width    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 smp_valid,
  input  logic [Amba_Word-1:0]                 smp_pixels,
  input  logic [Channels*Weight_precision-1:0] smp_weights,
  input  logic [Acc_width-1:0]                 dut_acc,
  input  logic                                 dut_acc_valid,
  input  logic                                 dut_cat,
  input  logic                                 dut_done,
  output logic [Acc_width-1:0]                 exp_acc,
  output logic [$clog2(Pixel_count+1)-1:0]     smp_count,
  output logic                                 busy,
  output logic                                 mismatch,
  output logic [Err_cnt_width-1:0]             err_count,
  output logic                                 result_valid,
  output logic                                 result_pass
);

  localparam int unsigned CNT_W = $clog2(Pixel_count + 1);
  localparam int unsigned TMR_W = $clog2(Timeout + 1);
  localparam int unsigned SUM_W = Err_cnt_width + 3;
  localparam logic signed [Acc_width-1:0] THR = Acc_width'(Threshold);

  sb_state_t             state, next_state;
  logic [Acc_width-1:0]  dot;
  logic [TMR_W-1:0]      timer;
  logic                  img_err;
  logic                  accept;
  logic                  exp_cat;
  logic                  stream_bad;
  logic [NUM_CAUSES-1:0] err_vec;
  logic [SUM_W-1:0]      err_sum;
  logic [Err_cnt_width-1:0] err_next;

  dot_product_unit #(
    .Channels        (Channels),
    .Pixel_width     (Pixel_width),
    .Weight_precision(Weight_precision),
    .Acc_width       (Acc_width)
  ) u_dot (
    .pixels (smp_pixels),
    .weights(smp_weights),
    .dot    (dot)
  );

  // Stream compare uses the registered exp_acc, so a sample accepted in the
  // same cycle is not yet included.
  always_comb begin
    exp_cat    = $signed(exp_acc) > THR;
    stream_bad = (Stream_check != 0) && dut_acc_valid && (dut_acc != exp_acc);
    next_state = state;
    accept     = 1'b0;
    err_vec    = '0;
    if (start && state != IDLE) begin
      // Abort: everything else this cycle is discarded.
      next_state = ACCUM;
    end else begin
      case (state)
        IDLE: if (start) next_state = ACCUM;
        ACCUM: begin
          err_vec[STREAM_MISMATCH] = stream_bad;
          if (dut_done) begin
            err_vec[EARLY_DONE] = 1'b1;
            next_state          = REPORT;
          end else if (smp_valid) begin
            accept = 1'b1;
            if (smp_count == CNT_W'(Pixel_count - 1)) next_state = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          err_vec[STREAM_MISMATCH] = stream_bad;
          err_vec[OVERRUN]         = smp_valid;
          if (dut_done) begin
            err_vec[ACC_MISMATCH] = (dut_acc != exp_acc);
            err_vec[CAT_MISMATCH] = (dut_cat != exp_cat);
            next_state            = REPORT;
          end else if (timer == TMR_W'(Timeout - 1)) begin
            err_vec[TIMEOUT] = 1'b1;
            next_state       = REPORT;
          end
        end
        REPORT:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
    err_sum  = {3'b000, err_count} + SUM_W'($countones(err_vec));
    err_next = (err_sum[SUM_W-1:Err_cnt_width] != '0) ? '1 : err_sum[Err_cnt_width-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      exp_acc      <= '0;
      smp_count    <= '0;
      timer        <= '0;
      img_err      <= 1'b0;
      busy         <= 1'b0;
      mismatch     <= 1'b0;
      err_count    <= '0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= (next_state == ACCUM) || (next_state == WAIT_DONE);
      mismatch     <= |err_vec;
      err_count    <= err_next;
      result_valid <= (next_state == REPORT);
      result_pass  <= (next_state == REPORT) && !img_err && !(|err_vec);
      if (state == WAIT_DONE && next_state == WAIT_DONE) timer <= timer + 1'b1;
      else                                               timer <= '0;
      if (start) begin
        exp_acc   <= '0;
        smp_count <= '0;
        img_err   <= 1'b0;
      end else begin
        if (accept) begin
          exp_acc   <= exp_acc + dot;
          smp_count <= smp_count + 1'b1;
        end
        if (|err_vec) img_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_scoreboard.sv
module tb_acc_scoreboard;

  logic        clk = 1'b0;
  logic        rst, start, smp_valid, dut_acc_valid, dut_cat, dut_done;
  logic [23:0] smp_pixels;
  logic [14:0] smp_weights;
  logic [63:0] dut_acc;
  logic [63:0] exp_acc;
  logic [2:0]  smp_count;
  logic        busy, mismatch, result_valid, result_pass;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [23:0] PIX_FF  = 24'hFFFFFF;
  localparam logic [14:0] W_M16   = 15'h4210;  // -16 on every channel
  localparam logic [23:0] PIX_123 = 24'h030201;
  localparam logic [14:0] W_15    = 15'h3DEF;  // +15 on every channel

  acc_scoreboard #(
    .Pixel_count(4),
    .Timeout    (8),
    .Threshold  (0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .smp_pixels(smp_pixels), .smp_weights(smp_weights),
    .dut_acc(dut_acc), .dut_acc_valid(dut_acc_valid), .dut_cat(dut_cat),
    .dut_done(dut_done), .exp_acc(exp_acc), .smp_count(smp_count),
    .busy(busy), .mismatch(mismatch), .err_count(err_count),
    .result_valid(result_valid), .result_pass(result_pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [23:0] p, input logic [14:0] w);
    smp_pixels = p; smp_weights = w; smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; smp_valid = 0; dut_acc_valid = 0; dut_cat = 0; dut_done = 0;
    smp_pixels = '0; smp_weights = '0; dut_acc = '0;
    tick(); tick();
    checks++; if ({exp_acc, smp_count, busy, mismatch, err_count, result_valid, result_pass} !== '0) begin
      failures++; $display("FAIL reset_outputs: got acc=%0h cnt=%0d busy=%0b err=%0d rv=%0b expected all zero", exp_acc, smp_count, busy, err_count, result_valid); end
    rst = 1'b0;
  endtask

  task automatic run_ff_image();
    logic signed [63:0] e;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %0b expected 1", busy); end
    for (int i = 1; i <= 4; i++) begin
      sample(PIX_FF, W_M16);
      e = -64'sd12240 * i;
      checks++; if (exp_acc !== e) begin failures++; $display("FAIL ff_step%0d: got %0d expected %0d", i, $signed(exp_acc), e); end
      checks++; if (smp_count !== 3'(i)) begin failures++; $display("FAIL ff_count%0d: got %0d expected %0d", i, smp_count, i); end
    end
  endtask

  task automatic test_pass_image();
    run_ff_image();
    dut_acc = -64'sd48960; dut_cat = 1'b0; dut_done = 1'b1; tick(); dut_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b1) begin failures++; $display("FAIL pass_report: got rv=%0b rp=%0b expected 1 1", result_valid, result_pass); end
    checks++; if (err_count !== 16'd0 || mismatch !== 1'b0) begin failures++; $display("FAIL pass_errs: got err=%0d mm=%0b expected 0 0", err_count, mismatch); end
    tick();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL pass_idle: got rv=%0b busy=%0b expected 0 0", result_valid, busy); end
  endtask

  task automatic test_cat_mismatch();
    run_ff_image();
    dut_acc = -64'sd48960; dut_cat = 1'b1; dut_done = 1'b1; tick(); dut_done = 1'b0; dut_cat = 1'b0;
    checks++; if (mismatch !== 1'b1 || err_count !== 16'd1) begin failures++; $display("FAIL cat_err: got mm=%0b err=%0d expected 1 1", mismatch, err_count); end
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b0) begin failures++; $display("FAIL cat_report: got rv=%0b rp=%0b expected 1 0", result_valid, result_pass); end
    tick();
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL cat_pulse_len: got mm=%0b expected 0", mismatch); end
  endtask

  task automatic test_stream_check();
    start = 1'b1; tick(); start = 1'b0;
    sample(PIX_123, W_15);
    checks++; if (exp_acc !== 64'd90) begin failures++; $display("FAIL stream_acc: got %0d expected 90", exp_acc); end
    dut_acc = 64'd89; dut_acc_valid = 1'b1; tick();
    checks++; if (mismatch !== 1'b1 || err_count !== 16'd2) begin failures++; $display("FAIL stream_bad: got mm=%0b err=%0d expected 1 2", mismatch, err_count); end
    dut_acc = 64'd90; tick(); dut_acc_valid = 1'b0;
    checks++; if (mismatch !== 1'b0 || err_count !== 16'd2) begin failures++; $display("FAIL stream_good: got mm=%0b err=%0d expected 0 2", mismatch, err_count); end
    // abort mid-image: start wins over a simultaneous sample
    start = 1'b1; smp_pixels = PIX_FF; smp_weights = W_M16; smp_valid = 1'b1; tick();
    start = 1'b0; smp_valid = 1'b0;
    checks++; if (smp_count !== 3'd0 || exp_acc !== 64'd0 || busy !== 1'b1 || result_valid !== 1'b0) begin
      failures++; $display("FAIL abort: got cnt=%0d acc=%0d busy=%0b rv=%0b expected 0 0 1 0", smp_count, exp_acc, busy, result_valid); end
  endtask

  task automatic test_early_done_overrun();
    start = 1'b1; tick(); start = 1'b0;
    sample(PIX_FF, W_M16); sample(PIX_FF, W_M16);
    dut_done = 1'b1; tick(); dut_done = 1'b0;
    checks++; if (mismatch !== 1'b1 || err_count !== 16'd3 || result_valid !== 1'b1 || result_pass !== 1'b0) begin
      failures++; $display("FAIL early_done: got mm=%0b err=%0d rv=%0b rp=%0b expected 1 3 1 0", mismatch, err_count, result_valid, result_pass); end
    tick();
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL early_idle: got busy=%0b rv=%0b expected 0 0", busy, result_valid); end
    run_ff_image();
    sample(PIX_FF, W_M16);
    checks++; if (mismatch !== 1'b1 || err_count !== 16'd4 || smp_count !== 3'd4 || exp_acc !== -64'sd48960) begin
      failures++; $display("FAIL overrun: got mm=%0b err=%0d cnt=%0d acc=%0d expected 1 4 4 -48960", mismatch, err_count, smp_count, $signed(exp_acc)); end
    dut_acc = -64'sd48960; dut_cat = 1'b0; dut_done = 1'b1; tick(); dut_done = 1'b0;
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b0 || mismatch !== 1'b0 || err_count !== 16'd4) begin
      failures++; $display("FAIL overrun_report: got rv=%0b rp=%0b mm=%0b err=%0d expected 1 0 0 4", result_valid, result_pass, mismatch, err_count); end
    tick();
  endtask

  task automatic test_timeout();
    run_ff_image();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL timeout_early%0d: got rv=%0b busy=%0b expected 0 1", i, result_valid, busy); end
    end
    tick();
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b0 || mismatch !== 1'b1 || err_count !== 16'd5) begin
      failures++; $display("FAIL timeout: got rv=%0b rp=%0b mm=%0b err=%0d expected 1 0 1 5", result_valid, result_pass, mismatch, err_count); end
    tick();
    start = 1'b1; smp_pixels = PIX_FF; smp_weights = W_M16; smp_valid = 1'b1; tick();
    start = 1'b0; smp_valid = 1'b0;
    checks++; if (smp_count !== 3'd0 || busy !== 1'b1) begin failures++; $display("FAIL start_with_sample: got cnt=%0d busy=%0b expected 0 1", smp_count, busy); end
  endtask

  task automatic test_reset_mid_and_saturate();
    sample(PIX_FF, W_M16);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({exp_acc, smp_count, busy, mismatch, err_count, result_valid, result_pass} !== '0) begin
      failures++; $display("FAIL reset_mid: got acc=%0h cnt=%0d busy=%0b err=%0d rv=%0b expected all zero", exp_acc, smp_count, busy, err_count, result_valid); end
    tick();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_no_report: got rv=%0b busy=%0b expected 0 0", result_valid, busy); end
    start = 1'b1; tick(); start = 1'b0;
    dut_acc = 64'd1; dut_acc_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (err_count !== 16'd65535) begin failures++; $display("FAIL sat_reach: got %0d expected 65535", err_count); end
    repeat (70000 - 65535) @(posedge clk);
    #1;
    dut_acc_valid = 1'b0;
    checks++; if (err_count !== 16'hFFFF || mismatch !== 1'b1) begin failures++; $display("FAIL sat_hold: got err=%0d mm=%0b expected 65535 1", err_count, mismatch); end
  endtask

  initial begin
    test_reset();
    test_pass_image();
    test_cat_mismatch();
    test_stream_check();
    test_early_done_overrun();
    test_timeout();
    test_reset_mid_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
